// File: rtl/regfile_mp.sv
// regfile_mp - parametrised multi-read-port register file for the thread datapath.
//
// Sits between decode (reads, scoreboard issue) and writeback (writes).
// r0 is hard-wired to zero and is never marked busy. Writes are either scalar
// or paired-lane (even/odd pair). A per-register busy scoreboard tracks pending
// long-latency writebacks. A sequential clear engine zeroes r1..r(NREGS-1),
// one register per cycle.
//
// Parameters:
//   DW     register width
//   NREGS  register count including r0 (power of two, >= 4)
//   NRD    number of read ports
//   AW     address width, derived from NREGS
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rd_addr/rd_data      NRD combinational read ports, port k at [k*AW +: AW] / [k*DW +: DW]
//   rd_busy              scoreboard bit of each addressed register
//   wr_en/wr_simd/...    write port; SIMD writes the even/odd pair (low lane -> even)
//   iss_en/iss_simd/...  scoreboard issue (marks register or pair busy)
//   clr_req              pulse that starts the clear sweep
//   clr_busy             clear sweep in progress
//   wr_ready             writes accepted (low while clearing)
//
// Build option:
//   REGFILE_BYPASS_EN    when defined, reads of a register being written in the
//                        current cycle return the incoming write data.

module regfile_mp #(
  parameter int DW = 28,
  parameter int NREGS = 16,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic              wr_simd,
  input  logic [AW-1:0]     wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              iss_en,
  input  logic              iss_simd,
  input  logic [AW-1:0]     iss_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_ready
);

  // state   | meaning
  // S_IDLE  | normal operation, writes accepted
  // S_CLEAR | sweeping cidx = 1..NREGS-1, zeroing one register per cycle
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cidx, cidx_nxt;

  logic [DW-1:0]   rf [NREGS];
  logic [NREGS-1:0] busy;

  logic [NREGS-1:0] we_vec;
  logic [NREGS-1:0] iss_vec;
  logic [NREGS-1:0] clr_vec;
  logic [DW-1:0]    wd_vec [NREGS];
  logic             wr_acc;
  logic [AW-1:0]    ra;

  // Clear FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cidx  <= AW'(1);
    end else begin
      state <= state_nxt;
      cidx  <= cidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cidx_nxt  = cidx;
    clr_vec   = '0;
    case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_nxt = S_CLEAR;
          cidx_nxt  = AW'(1);
        end
      end
      S_CLEAR: begin
        clr_vec[cidx] = 1'b1;
        if (cidx == AW'(NREGS - 1)) begin
          state_nxt = S_IDLE;
          cidx_nxt  = AW'(1);
        end else begin
          cidx_nxt = cidx + AW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign clr_busy = (state == S_CLEAR);
  assign wr_ready = ~clr_busy;
  assign wr_acc   = wr_en & wr_ready;

  // Per-register write/issue decode. Pairs share all address bits but bit 0;
  // r0 is masked out last so the pairing rule for E = 0 falls out naturally.
  always_comb begin
    we_vec  = '0;
    iss_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      wd_vec[i] = (wr_simd && i[0]) ? wr_data[2*DW-1:DW] : wr_data[DW-1:0];
      if (wr_acc) begin
        if (wr_simd) we_vec[i] = ((AW'(i) >> 1) == (wr_addr >> 1));
        else         we_vec[i] = (AW'(i) == wr_addr);
      end
      if (iss_en) begin
        if (iss_simd) iss_vec[i] = ((AW'(i) >> 1) == (iss_addr >> 1));
        else          iss_vec[i] = (AW'(i) == iss_addr);
      end
    end
    we_vec[0]  = 1'b0;
    iss_vec[0] = 1'b0;
  end

  // Storage. rf[0] is only ever reset, so it reads as zero. Writes and the
  // sweep never coincide (writes are blocked while clearing); an issue always
  // overrides a clearing write or sweep on the busy bit since it is newer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (we_vec[i])       rf[i] <= wd_vec[i];
        else if (clr_vec[i]) rf[i] <= '0;

        if (iss_vec[i])                   busy[i] <= 1'b1;
        else if (we_vec[i] || clr_vec[i]) busy[i] <= 1'b0;
      end
    end
  end

  // Read ports
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      rd_data[k*DW +: DW] = rf[ra];
      rd_busy[k]          = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // we_vec[0] is never set, so r0 is never bypassed.
      if (we_vec[ra]) begin
        rd_data[k*DW +: DW] = wd_vec[ra];
        rd_busy[k]          = iss_vec[ra];
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance (DW=28, NREGS=16, NRD=2)
  logic [7:0]  rd_addr = '0;
  logic [55:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 0, wr_simd = 0, iss_en = 0, iss_simd = 0, clr_req = 0;
  logic [3:0]  wr_addr = '0, iss_addr = '0;
  logic [55:0] wr_data = '0;
  logic        clr_busy, wr_ready;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_simd(wr_simd), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_simd(iss_simd), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_ready(wr_ready)
  );

  // wide instance (DW=32, NREGS=32, NRD=3)
  logic [14:0] b_rd_addr = '0;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en = 0, b_wr_simd = 0, b_iss_en = 0, b_iss_simd = 0, b_clr_req = 0;
  logic [4:0]  b_wr_addr = '0, b_iss_addr = '0;
  logic [63:0] b_wr_data = '0;
  logic        b_clr_busy, b_wr_ready;

  regfile_mp #(.DW(32), .NREGS(32), .NRD(3)) u_dut32 (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_simd(b_wr_simd), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_simd(b_iss_simd), .iss_addr(b_iss_addr),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .wr_ready(b_wr_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the default instance: a register array, a busy array
  // and a countdown of remaining sweep cycles with the index being zeroed.
  logic [27:0] m_rf [16];
  logic        m_bz [16];
  int          m_rem;
  int          m_pos;

  function automatic logic [15:0] tmask(input logic [3:0] a, input logic simd);
    logic [15:0] m;
    if (simd) m = 16'h3 << {a[3:1], 1'b0};
    else      m = 16'h1 << a;
    m[0] = 1'b0;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [15:0] wm, im;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_rf[i] <= '0;
        m_bz[i] <= 1'b0;
      end
      m_rem <= 0;
      m_pos <= 1;
    end else begin
      wm = (wr_en && m_rem == 0) ? tmask(wr_addr, wr_simd) : 16'h0;
      im = iss_en ? tmask(iss_addr, iss_simd) : 16'h0;
      for (int i = 1; i < 16; i++) begin
        if (wm[i])                         m_rf[i] <= (wr_simd && i[0]) ? wr_data[55:28] : wr_data[27:0];
        else if (m_rem > 0 && m_pos == i)  m_rf[i] <= '0;
        if (im[i])                                   m_bz[i] <= 1'b1;
        else if (wm[i] || (m_rem > 0 && m_pos == i)) m_bz[i] <= 1'b0;
      end
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        m_pos <= m_pos + 1;
      end else if (clr_req) begin
        m_rem <= 15;
        m_pos <= 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0]  a;
    logic [27:0] ed;
    logic        eb;
    for (int k = 0; k < 2; k++) begin
      a  = rd_addr[k*4 +: 4];
      ed = m_rf[a];
      eb = m_bz[a];
`ifdef REGFILE_BYPASS_EN
      begin
        logic [15:0] wm, im;
        wm = (wr_en && m_rem == 0) ? tmask(wr_addr, wr_simd) : 16'h0;
        im = iss_en ? tmask(iss_addr, iss_simd) : 16'h0;
        if (wm[a]) begin
          ed = (wr_simd && a[0]) ? wr_data[55:28] : wr_data[27:0];
          eb = im[a];
        end
      end
`endif
      chk($sformatf("model rd_data[%0d] r%0d", k, a), 96'(rd_data[k*28 +: 28]), 96'(ed));
      chk($sformatf("model rd_busy[%0d] r%0d", k, a), 96'(rd_busy[k]), 96'(eb));
    end
    chk("model clr_busy", 96'(clr_busy), 96'(m_rem > 0));
    chk("model wr_ready", 96'(wr_ready), 96'(m_rem == 0));
  end

  task automatic idle();
    wr_en = 0; wr_simd = 0; iss_en = 0; iss_simd = 0; clr_req = 0;
    b_wr_en = 0; b_wr_simd = 0; b_iss_en = 0; b_iss_simd = 0; b_clr_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic simd, input logic [55:0] d);
    wr_en = 1; wr_simd = simd; wr_addr = a; wr_data = d;
  endtask

  task automatic bwr(input logic [4:0] a, input logic [63:0] d);
    b_wr_en = 1; b_wr_simd = 0; b_wr_addr = a; b_wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset rd_data", 96'(rd_data), 96'h0);
    chk("reset rd_busy", 96'(rd_busy), 96'h0);
    chk("reset clr_busy", 96'(clr_busy), 96'h0);
    chk("reset wr_ready", 96'(wr_ready), 96'h1);
    chk("reset b_clr_busy", 96'(b_clr_busy), 96'h0);

    // scalar write r5, read on port 1
    wr(4'd5, 1'b0, 56'h1234567);
    step(); idle();
    rd_addr = {4'd5, 4'd0}; #1;
    chk("scalar r5 port1", 96'(rd_data[55:28]), 96'h1234567);
    // write to r0 discarded
    wr(4'd0, 1'b0, 56'hFFFFFFF);
    step(); idle();
    rd_addr = {4'd5, 4'd0}; #1;
    chk("r0 reads zero", 96'(rd_data[27:0]), 96'h0);

    // SIMD write pair r6/r7
    wr(4'd7, 1'b1, {28'hAAAAAAA, 28'h5555555});
    step(); idle();
    rd_addr = {4'd7, 4'd6}; #1;
    chk("simd r6 low lane", 96'(rd_data[27:0]), 96'h5555555);
    chk("simd r7 high lane", 96'(rd_data[55:28]), 96'hAAAAAAA);
    // SIMD to pair 0/1: r0 stays zero
    wr(4'd1, 1'b1, {28'h1111111, 28'h2222222});
    step(); idle();
    rd_addr = {4'd1, 4'd0}; #1;
    chk("simd r0 untouched", 96'(rd_data[27:0]), 96'h0);
    chk("simd r1 high lane", 96'(rd_data[55:28]), 96'h1111111);

    // scoreboard
    iss_en = 1; iss_simd = 1; iss_addr = 4'd3;
    step(); idle();
    rd_addr = {4'd3, 4'd2}; #1;
    chk("issue pair r2/r3 busy", 96'(rd_busy), 96'h3);
    wr(4'd2, 1'b0, 56'h0000222);
    step(); idle();
    rd_addr = {4'd3, 4'd2}; #1;
    chk("write r2 clears busy", 96'(rd_busy), 96'h2);
    wr(4'd4, 1'b0, 56'h0000444);
    iss_en = 1; iss_simd = 0; iss_addr = 4'd4;
    step(); idle();
    rd_addr = {4'd4, 4'd4}; #1;
    chk("issue+write r4 busy", 96'(rd_busy), 96'h3);
    chk("issue+write r4 data", 96'(rd_data[27:0]), 96'h0000444);

    // bypass
    wr(4'd9, 1'b0, 56'h0111111);
    step(); idle();
    wr(4'd9, 1'b0, 56'h0ABCDEF);
    rd_addr = {4'd9, 4'd9}; #1;
`ifdef REGFILE_BYPASS_EN
    chk("same-cycle read r9", 96'(rd_data[27:0]), 96'h0ABCDEF);
`else
    chk("same-cycle read r9", 96'(rd_data[27:0]), 96'h0111111);
`endif
    chk("same-cycle busy r9", 96'(rd_busy[0]), 96'h0);
    step(); idle(); #1;
    chk("r9 after write", 96'(rd_data[27:0]), 96'h0ABCDEF);

    // fill r1..r15, then sweep
    for (int i = 1; i < 16; i++) begin
      wr(4'(i), 1'b0, 56'(i * 28'h0101011));
      step();
    end
    idle();
    clr_req = 1;
    step(); idle();
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 40) begin
      cnt++;
      idle();
      if (cnt == 4) wr(4'd2, 1'b0, 56'h0333333);
      if (cnt == 6) clr_req = 1;
      if (cnt == 10) begin iss_en = 1; iss_addr = 4'd10; end
      step();
    end
    idle();
    chk("clr_busy cycles", 96'(cnt), 96'd15);
    rd_addr = {4'd2, 4'd10}; #1;
    chk("issue wins over sweep r10", 96'(rd_busy), 96'h1);
    chk("dropped write r2", 96'(rd_data[55:28]), 96'h0);
    for (int i = 0; i < 16; i += 2) begin
      rd_addr = {4'(i + 1), 4'(i)}; #1;
      chk($sformatf("cleared r%0d/r%0d", i, i + 1), 96'(rd_data), 96'h0);
    end
    step();

    // reset mid-sweep
    wr(4'd15, 1'b0, 56'h0F0F0F0);
    step(); idle();
    clr_req = 1;
    step(); idle();
    repeat (5) step();
    chk("sweep running before rst", 96'(clr_busy), 96'h1);
    rst = 1'b1; #1;
    chk("rst mid-sweep clr_busy", 96'(clr_busy), 96'h0);
    chk("rst mid-sweep wr_ready", 96'(wr_ready), 96'h1);
    rd_addr = {4'd15, 4'd10}; #1;
    chk("rst mid-sweep data", 96'(rd_data), 96'h0);
    chk("rst mid-sweep busy", 96'(rd_busy), 96'h0);
    step();
    rst = 1'b0;
    step(); step();

    // wide instance: r31 on all three ports
    bwr(5'd31, 64'hDEADBEEF);
    step(); idle();
    b_rd_addr = {5'd31, 5'd31, 5'd31}; #1;
    chk("w32 r31 all ports", b_rd_data, {3{32'hDEADBEEF}});
    bwr(5'd0, 64'hFFFFFFFF);
    step(); idle();
    b_rd_addr = {5'd0, 5'd31, 5'd31}; #1;
    chk("w32 r0 zero", 96'(b_rd_data[95:64]), 96'h0);
    b_iss_en = 1; b_iss_simd = 1; b_iss_addr = 5'd31;
    step(); idle();
    b_rd_addr = {5'd31, 5'd30, 5'd31}; #1;
    chk("w32 issue pair busy", 96'(b_rd_busy), 96'h7);
    bwr(5'd30, 64'h30303030);
    step(); idle();
    b_rd_addr = {5'd31, 5'd30, 5'd31}; #1;
    chk("w32 write r30 busy", 96'(b_rd_busy), 96'h5);
    chk("w32 write r30 data", 96'(b_rd_data[63:32]), 96'h30303030);
    bwr(5'd31, 64'h31313131);
    b_iss_en = 1; b_iss_simd = 0; b_iss_addr = 5'd31;
    step(); idle();
    b_rd_addr = {5'd31, 5'd31, 5'd31}; #1;
    chk("w32 issue+write r31 busy", 96'(b_rd_busy), 96'h7);
    chk("w32 issue+write r31 data", b_rd_data, {3{32'h31313131}});
    b_clr_req = 1;
    step(); idle();
    cnt = 0;
    while (b_clr_busy === 1'b1 && cnt < 80) begin
      cnt++;
      step();
    end
    chk("w32 clr_busy cycles", 96'(cnt), 96'd31);
    b_rd_addr = {5'd31, 5'd30, 5'd1}; #1;
    chk("w32 cleared data", b_rd_data, 96'h0);
    chk("w32 cleared busy", 96'(b_rd_busy), 96'h0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the thread datapath, successor to the fixed 15×28 thread register file. Adds configurable width, depth and read-port count, paired-lane SIMD writes, a per-register busy scoreboard for long-latency writebacks, and a sequential clear engine. Sits between decode (reads and scoreboard issue) and writeback (writes).

## Interface
- `DW`, 28, register width in bits.
- `NREGS`, 16, register count including r0; power of two, ≥4.
- `NRD`, 2, number of read ports.
- `AW`, `$clog2(NREGS)`, address width; derived, not overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rd_addr`  in  NRD*AW  read addresses; port k uses `[k*AW +: AW]`.
- `rd_data`  out  NRD*DW  read data, combinational from `rd_addr`.
- `rd_busy`  out  NRD  scoreboard busy bit of each addressed register.
- `wr_en`  in  1  write strobe.
- `wr_simd`  in  1  paired-lane write.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  2*DW  write data; the low lane is `[DW-1:0]`.
- `iss_en`  in  1  mark a register busy (pending writeback).
- `iss_simd`  in  1  mark the even/odd pair busy.
- `iss_addr`  in  AW  issue address.
- `clr_req`  in  1  single-cycle pulse that starts the clear sweep.
- `clr_busy`  out  1  clear sweep in progress.
- `wr_ready`  out  1  writes are accepted; low while clearing.

## Operation
- **r0:**
  - Reads as 0.
  - Writes to r0 are discarded.
  - The busy bit for r0 is never set.
- **Scalar write** (`wr_en & ~wr_simd & wr_ready`):
  - Writes `rf[wr_addr] <= wr_data[DW-1:0]`.
  - Clears `busy[wr_addr]`.
- **SIMD write** (`wr_en & wr_simd & wr_ready`):
  - `wr_addr[0]` is ignored.
  - Even register `E` = `{wr_addr[AW-1:1],0}` gets the low lane.
  - Register `E+1` gets `wr_data[2*DW-1:DW]`.
  - Clears both busy bits.
  - If `E` = 0, only the high lane is written.
- **Issue:**
  - `iss_en` sets `busy[iss_addr]`, or both pair bits when `iss_simd` is set (same pairing rule as SIMD write).
  - Issue is accepted in every state, including CLEAR.
- **Simultaneous issue and write to the same register:**
  - The write data is stored.
  - The busy bit ends set, because the issue is newer.
- **Clear FSM** (states IDLE and CLEAR):
  - IDLE → CLEAR on `clr_req`. The counter `cidx` loads 1.
  - In CLEAR, each cycle zeroes `rf[cidx]` and `busy[cidx]`, then increments `cidx`.
  - CLEAR → IDLE after `cidx` = NREGS-1 is cleared. The sweep takes NREGS-1 cycles.
  - `clr_busy` = (state == CLEAR). `wr_ready` = ~`clr_busy`.
  - Writes presented while `wr_ready` = 0 are dropped with no effect.
  - `clr_req` is ignored while the FSM is in CLEAR.
  - A busy bit set by an issue in the same cycle that the sweep clears that index: the issue wins.
- **Reset:**
  - All registers = 0, all busy = 0, state = IDLE, `cidx` = 1.
  - Reset takes effect immediately, including mid-sweep.

## Timing
- Read latency 0: `rd_data` and `rd_busy` follow `rd_addr` and the array state combinationally.
- A write becomes visible on reads the cycle after its edge; with bypass enabled (see Configuration), it is visible in the same cycle.
- An issue becomes visible on `rd_busy` the cycle after its edge.
- `clr_busy` rises on the edge that samples `clr_req`. It falls on the edge after the last index is cleared, which is NREGS-1 cycles after it rose.
- Outputs after reset:
  - `rd_data` = 0 for all addresses.
  - `rd_busy` = 0.
  - `clr_busy` = 0.
  - `wr_ready` = 1.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read port whose address matches an accepted write in the current cycle returns `wr_data` (the correct lane for SIMD writes).
  - That port reports `rd_busy` = 0, unless `iss_en` targets the same register in that cycle.
  - r0 is never bypassed.
- `REGFILE_BYPASS_EN` undefined: reads return stored array contents only.

## Test plan
- **Reset, then scalar write:** assert `rst`, release, write r5 = 0x1234567, read r5 on port 1 next cycle → 0x1234567; r0 reads 0 after a write of 0xFFFFFFF to r0.
- **SIMD write:** `wr_addr` = 7, `wr_data` = {0xAAAAAAA, 0x5555555} → r6 = 0x5555555, r7 = 0xAAAAAAA. `wr_addr` = 1 → r0 stays 0, r1 takes the high lane.
- **Scoreboard:**
  - Issue r3 SIMD → `rd_busy` on r2 and r3 = 1.
  - Scalar write r2 → r2 busy 0, r3 busy 1.
  - Same-cycle issue and write on r4 → r4 busy = 1, data stored.
- **Clear:**
  - Fill r1..r15, pulse `clr_req` → `clr_busy` high for exactly 15 cycles, all reads 0 afterwards.
  - A write during the sweep is dropped.
  - Assert `rst` at sweep cycle 6 → `clr_busy` = 0 immediately.
- **Bypass** (`REGFILE_BYPASS_EN` defined): read r9 while writing r9 = 0x0ABCDEF → same-cycle `rd_data` = 0x0ABCDEF. With the macro undefined → the old value.
- **Parameter sweep:** DW = 32, NREGS = 32, NRD = 3 → repeat the scalar and scoreboard scenarios on r31 across all three ports.
